touch_event: RTL



---
 rtl/touch_event.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/touch_event.sv
// Touch event conditioner: sampled debounce, press/release/hold pulses and a 4-tap filtered, clamped position.
// Optional macro TOUCH_EVT_ROTATE_EN rotates the reported position 90 degrees for a landscape panel.
module touch_event #(
  parameter logic [23:0] SAMPLE_DIV   = 24'd500000,
  parameter logic [3:0]  DEBOUNCE     = 4'd3,
  parameter logic [7:0]  HOLD_SAMPLES = 8'd50,
  parameter logic [15:0] XMAX         = 16'd239,
  parameter logic [15:0] YMAX         = 16'd319
) (
  input  logic        clk,
  input  logic        arstn,
  input  logic        touch,
  input  logic [15:0] touchx,
  input  logic [15:0] touchy,
  output logic        pressed,
  output logic        press_pulse,
  output logic        release_pulse,
  output logic        hold_pulse,
  output logic        pos_valid,
  output logic [15:0] posx,
  output logic [15:0] posy,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ARMING    = 3'd1,
    S_ACTIVE    = 3'd2,
    S_HELD      = 3'd3,
    S_RELEASING = 3'd4
  } state_t;

  state_t            state_q, state_d, base_st;
  logic [23:0]       tick_cnt_q, tick_cnt_d;
  logic [3:0]        deb_q, deb_d, deb_inc;
  logic [7:0]        hold_q, hold_d, hold_inc;
  logic              held_q, held_d;
  logic              pressed_q, pressed_d;
  logic              press_q, press_d, rel_q, rel_d, holdp_q, holdp_d, posv_q, posv_d;
  logic [3:0][15:0]  tx_q, tx_d, ty_q, ty_d;
  logic [15:0]       posx_q, posx_d, posy_q, posy_d;
  logic              tick, deb_done, load, shift;
  logic [17:0]       sum_x, sum_y;
  logic [15:0]       avg_x, avg_y, clamp_x, clamp_y;

  assign tick     = (tick_cnt_q == SAMPLE_DIV - 24'd1);
  assign deb_inc  = deb_q + 4'd1;
  assign deb_done = (deb_inc == DEBOUNCE);
  assign hold_inc = hold_q + 8'd1;

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick ? 24'd0 : tick_cnt_q + 24'd1;
    deb_d      = deb_q;
    hold_d     = hold_q;
    held_d     = held_q;
    pressed_d  = pressed_q;
    press_d    = 1'b0;
    rel_d      = 1'b0;
    holdp_d    = 1'b0;
    load       = 1'b0;
    shift      = 1'b0;
    base_st    = state_q;
    if (tick) begin
      case (state_q)
        S_IDLE, S_ARMING: begin
          if (!touch) begin
            state_d = S_IDLE;
            deb_d   = 4'd0;
          end else if (deb_done) begin
            state_d   = S_ACTIVE;
            pressed_d = 1'b1;
            press_d   = 1'b1;
            load      = 1'b1;
            deb_d     = 4'd0;
            hold_d    = 8'd0;
          end else begin
            state_d = S_ARMING;
            deb_d   = deb_inc;
          end
        end
        S_ACTIVE, S_HELD, S_RELEASING: begin
          // base_st is where a touched sample returns to; the hold count only advances in ACTIVE.
          if (state_q == S_RELEASING) begin
            base_st = held_q ? S_HELD : S_ACTIVE;
          end else if (state_q == S_ACTIVE) begin
            hold_d = hold_inc;
            if (hold_inc == HOLD_SAMPLES) begin
              holdp_d = 1'b1;
              base_st = S_HELD;
            end
          end
          if (touch) begin
            state_d = base_st;
            shift   = 1'b1;
            deb_d   = 4'd0;
          end else if (deb_done) begin
            state_d   = S_IDLE;
            pressed_d = 1'b0;
            rel_d     = 1'b1;
            hold_d    = 8'd0;
            held_d    = 1'b0;
            deb_d     = 4'd0;
          end else begin
            state_d = S_RELEASING;
            held_d  = (base_st == S_HELD);
            deb_d   = deb_inc;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    tx_d = tx_q;
    ty_d = ty_q;
    if (load) begin
      tx_d = {4{touchx}};
      ty_d = {4{touchy}};
    end else if (shift) begin
      tx_d = {tx_q[2:0], touchx};
      ty_d = {ty_q[2:0], touchy};
    end
    sum_x   = {2'b00, tx_d[0]} + {2'b00, tx_d[1]} + {2'b00, tx_d[2]} + {2'b00, tx_d[3]};
    sum_y   = {2'b00, ty_d[0]} + {2'b00, ty_d[1]} + {2'b00, ty_d[2]} + {2'b00, ty_d[3]};
    avg_x   = sum_x[17:2];
    avg_y   = sum_y[17:2];
    clamp_x = (avg_x > XMAX) ? XMAX : avg_x;
    clamp_y = (avg_y > YMAX) ? YMAX : avg_y;
    posv_d  = load | shift;
    posx_d  = posx_q;
    posy_d  = posy_q;
    if (load | shift) begin
`ifdef TOUCH_EVT_ROTATE_EN
      posx_d = YMAX - clamp_y;
      posy_d = clamp_x;
`else
      posx_d = clamp_x;
      posy_d = clamp_y;
`endif
    end
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state_q    <= S_IDLE;
      tick_cnt_q <= 24'd0;
      deb_q      <= 4'd0;
      hold_q     <= 8'd0;
      held_q     <= 1'b0;
      pressed_q  <= 1'b0;
      press_q    <= 1'b0;
      rel_q      <= 1'b0;
      holdp_q    <= 1'b0;
      posv_q     <= 1'b0;
      tx_q       <= '0;
      ty_q       <= '0;
      posx_q     <= 16'd0;
      posy_q     <= 16'd0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      deb_q      <= deb_d;
      hold_q     <= hold_d;
      held_q     <= held_d;
      pressed_q  <= pressed_d;
      press_q    <= press_d;
      rel_q      <= rel_d;
      holdp_q    <= holdp_d;
      posv_q     <= posv_d;
      tx_q       <= tx_d;
      ty_q       <= ty_d;
      posx_q     <= posx_d;
      posy_q     <= posy_d;
    end
  end

  assign pressed       = pressed_q;
  assign press_pulse   = press_q;
  assign release_pulse = rel_q;
  assign hold_pulse    = holdp_q;
  assign pos_valid     = posv_q;
  assign posx          = posx_q;
  assign posy          = posy_q;
  assign dbg_state     = state_q;

endmodule
